// File: rtl/ocp_mem_slave.sv
// ocp_mem_slave: single-outstanding OCP responder in front of a word-addressed register memory.
// Define OCP_MEM_SLAVE_BYTEEN_EN to apply request/data byte enables to write beats.
module ocp_mem_slave #(
  parameter int TAGI_WIDTH = 5,
  parameter int INFO_WIDTH = 4,
  parameter int BLEN_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              m_cmd,
  input  logic [ADDR_WIDTH-1:0]   m_addr,
  input  logic [BLEN_WIDTH-1:0]   m_burst_length,
  input  logic [2:0]              m_burst_seq,
  input  logic [DATA_WIDTH/8-1:0] m_byteen,
  input  logic [TAGI_WIDTH-1:0]   m_tagid,
  input  logic [INFO_WIDTH-1:0]   m_req_info,
  input  logic [DATA_WIDTH-1:0]   m_data,
  input  logic [DATA_WIDTH/8-1:0] m_data_byteen,
  input  logic [TAGI_WIDTH-1:0]   m_data_tagid,
  input  logic                    m_data_valid,
  input  logic                    m_data_last,
  input  logic                    m_resp_accept,
  output logic                    s_cmd_accept,
  output logic                    s_data_accept,
  output logic [1:0]              s_resp,
  output logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_resp_last,
  output logic [TAGI_WIDTH-1:0]   s_tagid
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(LANES);
  localparam int IDX_W = ADDR_WIDTH - OFF;
  localparam int DEPTH = 2 ** IDX_W;

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_RDEX = 3'd3;
  localparam logic [2:0] CMD_RDL  = 3'd4;
  localparam logic [2:0] CMD_WRNP = 3'd5;

  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_RESP, S_WRESP} state_t;

  state_t                  state;
  logic [2:0]              cmd_q;
  logic [IDX_W-1:0]        idx_q;
  logic [BLEN_WIDTH-1:0]   len_q;
  logic [BLEN_WIDTH-1:0]   beat_q;
  logic [TAGI_WIDTH-1:0]   tag_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [1:0]              resp_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    last_q;
  logic [TAGI_WIDTH-1:0]   rtag_q;

  logic [IDX_W-1:0]        word_in;
  logic [IDX_W-1:0]        idx_inc;
  logic [BLEN_WIDTH-1:0]   len_in;
  logic [BLEN_WIDTH-1:0]   beat_inc;
  logic                    req_read;
  logic                    req_err;
  logic                    last_beat;
  logic                    tag_ok;
  logic                    beat_bad;
  logic [LANES-1:0]        wmask;
  logic                    unused_inputs;

  assign word_in   = m_addr[ADDR_WIDTH-1:OFF];
  assign len_in    = (m_burst_length == '0) ? BLEN_WIDTH'(1) : m_burst_length;
  assign req_read  = m_cmd inside {CMD_RD, CMD_RDEX, CMD_RDL};
  assign req_err   = (m_burst_seq != 3'd0) || !(m_cmd inside {CMD_WR, CMD_RD, CMD_WRNP});
  assign idx_inc   = idx_q + IDX_W'(1);
  assign beat_inc  = beat_q + BLEN_WIDTH'(1);
  assign last_beat = (beat_q == len_q - BLEN_WIDTH'(1));
  assign tag_ok    = (m_data_tagid == tag_q);
  assign beat_bad  = !tag_ok || (m_data_last != last_beat);

`ifdef OCP_MEM_SLAVE_BYTEEN_EN
  logic [LANES-1:0] byteen_q;
  assign wmask         = m_data_byteen & byteen_q;
  assign unused_inputs = ^{m_req_info, m_addr};
`else
  assign wmask         = '1;
  assign unused_inputs = ^{m_req_info, m_addr, m_byteen, m_data_byteen};
`endif

  // Reset is visible on the outputs immediately, not only after the next edge.
  assign s_cmd_accept  = !rst && (state == S_IDLE);
  assign s_data_accept = !rst && (state == S_WDATA);
  assign s_resp        = rst ? RESP_NULL : resp_q;
  assign s_data        = rst ? '0 : data_q;
  assign s_resp_last   = !rst && last_q;
  assign s_tagid       = rst ? '0 : rtag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cmd_q  <= CMD_IDLE;
      idx_q  <= '0;
      len_q  <= '0;
      beat_q <= '0;
      tag_q  <= '0;
      err_q  <= 1'b0;
      resp_q <= RESP_NULL;
      data_q <= '0;
      last_q <= 1'b0;
      rtag_q <= '0;
`ifdef OCP_MEM_SLAVE_BYTEEN_EN
      byteen_q <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (m_cmd != CMD_IDLE) begin
            cmd_q  <= m_cmd;
            idx_q  <= word_in;
            len_q  <= len_in;
            beat_q <= '0;
            tag_q  <= m_tagid;
            err_q  <= req_err;
`ifdef OCP_MEM_SLAVE_BYTEEN_EN
            byteen_q <= m_byteen;
`endif
            if (req_read) begin
              state  <= S_RESP;
              resp_q <= req_err ? RESP_ERR : RESP_DVA;
              data_q <= req_err ? '0 : mem[word_in];
              last_q <= req_err || (len_in == BLEN_WIDTH'(1));
              rtag_q <= m_tagid;
            end else begin
              state <= S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (m_data_valid) begin
            if (!err_q && tag_ok) begin
              for (int b = 0; b < LANES; b++)
                if (wmask[b]) mem[idx_q][8*b +: 8] <= m_data[8*b +: 8];
            end
            err_q  <= err_q || beat_bad;
            idx_q  <= idx_inc;
            beat_q <= beat_inc;
            // Posted WR returns straight to IDLE; other write types owe a response.
            if (last_beat) begin
              if (cmd_q == CMD_WR) begin
                state <= S_IDLE;
              end else begin
                state  <= S_WRESP;
                resp_q <= (err_q || beat_bad) ? RESP_ERR : RESP_DVA;
                data_q <= '0;
                last_q <= 1'b1;
                rtag_q <= tag_q;
              end
            end
          end
        end
        S_RESP: begin
          if (m_resp_accept) begin
            if (last_q) begin
              state  <= S_IDLE;
              resp_q <= RESP_NULL;
              data_q <= '0;
              last_q <= 1'b0;
              rtag_q <= '0;
            end else begin
              idx_q  <= idx_inc;
              beat_q <= beat_inc;
              data_q <= mem[idx_inc];
              last_q <= (beat_inc == len_q - BLEN_WIDTH'(1));
            end
          end
        end
        S_WRESP: begin
          if (m_resp_accept) begin
            state  <= S_IDLE;
            resp_q <= RESP_NULL;
            data_q <= '0;
            last_q <= 1'b0;
            rtag_q <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ocp_mem_slave.sv
// Scoreboard bench for ocp_mem_slave: directed cases plus randomized transactions
// checked against a word-array reference model; a monitor pops expected response beats.
module tb_ocp_mem_slave;

  logic        clk;
  logic        rst;
  logic [2:0]  m_cmd;
  logic [4:0]  m_addr;
  logic [3:0]  m_burst_length;
  logic [2:0]  m_burst_seq;
  logic [3:0]  m_byteen;
  logic [4:0]  m_tagid;
  logic [3:0]  m_req_info;
  logic [31:0] m_data;
  logic [3:0]  m_data_byteen;
  logic [4:0]  m_data_tagid;
  logic        m_data_valid;
  logic        m_data_last;
  logic        m_resp_accept;
  logic        s_cmd_accept;
  logic        s_data_accept;
  logic [1:0]  s_resp;
  logic [31:0] s_data;
  logic        s_resp_last;
  logic [4:0]  s_tagid;

  ocp_mem_slave dut (
    .clk(clk), .rst(rst),
    .m_cmd(m_cmd), .m_addr(m_addr), .m_burst_length(m_burst_length),
    .m_burst_seq(m_burst_seq), .m_byteen(m_byteen), .m_tagid(m_tagid),
    .m_req_info(m_req_info), .m_data(m_data), .m_data_byteen(m_data_byteen),
    .m_data_tagid(m_data_tagid), .m_data_valid(m_data_valid), .m_data_last(m_data_last),
    .m_resp_accept(m_resp_accept),
    .s_cmd_accept(s_cmd_accept), .s_data_accept(s_data_accept), .s_resp(s_resp),
    .s_data(s_data), .s_resp_last(s_resp_last), .s_tagid(s_tagid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected response beat: {resp, data, last, tag}.
  logic [39:0] expQ[$];
  logic [31:0] wq[$];
  logic [31:0] memModel[8];
  logic [3:0]  dataByteen;
  int          nCompared  = 0;
  int          nMismatch  = 0;
  int          popCount   = 0;
  bit          acceptMode = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic bit isReadCmd(input logic [2:0] cmd);
    return (cmd == 3'd2) || (cmd == 3'd3) || (cmd == 3'd4);
  endfunction

  function automatic bit cmdErr(input logic [2:0] cmd, input logic [2:0] seq);
    return (seq != 3'd0) || !((cmd == 3'd1) || (cmd == 3'd2) || (cmd == 3'd5));
  endfunction

  // Monitor: every presented response beat must match the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_resp != 2'd0) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_resp", 64'({s_resp, s_data, s_resp_last, s_tagid}), 64'd0);
        end else begin
          checkOutput("resp_beat", 64'({s_resp, s_data, s_resp_last, s_tagid}), 64'(expQ[0]));
          if (m_resp_accept) begin
            void'(expQ.pop_front());
            popCount++;
          end
        end
      end else begin
        checkOutput("idle_outputs", 64'({s_data, s_resp_last, s_tagid}), 64'd0);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!acceptMode) m_resp_accept = ($urandom_range(0, 3) != 0);
  end

  task automatic applyStimulus(input logic [2:0] cmd, input logic [4:0] addr, input logic [3:0] blen,
                               input logic [2:0] seq, input logic [3:0] byteen, input logic [4:0] tag,
                               input int badTagBeat, input int badLastBeat, input bit waitDone);
    int len, idx, waitCnt;
    bit err;
    logic [31:0] d;
    logic [4:0]  dtag;
    logic        dlast;
    logic [3:0]  mask;
    len = (blen == 4'd0) ? 1 : int'(blen);
    idx = int'(addr >> 2);
    err = cmdErr(cmd, seq);
    waitCnt = 0;
    while (!s_cmd_accept && waitCnt < 100) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("cmd_accept_ready", 64'(s_cmd_accept), 64'd1);
    if (isReadCmd(cmd)) begin
      if (err) expQ.push_back({2'd3, 32'd0, 1'b1, tag});
      else for (int b = 0; b < len; b++)
        expQ.push_back({2'd1, memModel[(idx + b) % 8], (b == len - 1), tag});
    end
    m_cmd = cmd; m_addr = addr; m_burst_length = blen; m_burst_seq = seq;
    m_byteen = byteen; m_tagid = tag; m_req_info = 4'($urandom);
    @(posedge clk); #1;
    m_cmd = 3'd0;
    if (isReadCmd(cmd)) begin
      checkOutput("rd_latency", 64'(s_resp), err ? 64'd3 : 64'd1);
    end else begin
`ifdef OCP_MEM_SLAVE_BYTEEN_EN
      mask = dataByteen & byteen;
`else
      mask = 4'hF;
`endif
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          m_data_valid = 1'b0;
          checkOutput("data_accept_hold", 64'(s_data_accept), 64'd1);
          @(posedge clk); #1;
        end
        d     = (wq.size() != 0) ? wq.pop_front() : $urandom;
        dtag  = (b == badTagBeat) ? (tag ^ 5'h1) : tag;
        dlast = (b == len - 1) ^ (b == badLastBeat);
        m_data = d; m_data_tagid = dtag; m_data_last = dlast;
        m_data_byteen = dataByteen; m_data_valid = 1'b1;
        checkOutput("data_accept", 64'(s_data_accept), 64'd1);
        if (!err && dtag == tag)
          for (int l = 0; l < 4; l++)
            if (mask[l]) memModel[(idx + b) % 8][8*l +: 8] = d[8*l +: 8];
        if (dtag != tag || dlast != (b == len - 1)) err = 1'b1;
        @(posedge clk); #1;
      end
      m_data_valid = 1'b0;
      m_data_last  = 1'b0;
      if (cmd == 3'd1) begin
        checkOutput("wr_posted_idle", 64'({s_cmd_accept, s_resp}), 64'({1'b1, 2'd0}));
      end else begin
        expQ.push_back({err ? 2'd3 : 2'd1, 32'd0, 1'b1, tag});
        checkOutput("wresp_latency", 64'(s_resp), err ? 64'd3 : 64'd1);
      end
    end
    if (waitDone) begin
      waitCnt = 0;
      while ((expQ.size() != 0 || !s_cmd_accept) && waitCnt < 200) begin
        @(posedge clk); #1;
        waitCnt++;
      end
      checkOutput("txn_drain", 64'(expQ.size()), 64'd0);
      expQ.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pc;
    rst = 1'b1; m_cmd = 3'd0; m_addr = '0; m_burst_length = '0; m_burst_seq = '0;
    m_byteen = 4'hF; m_tagid = '0; m_req_info = '0; m_data = '0; m_data_byteen = 4'hF;
    m_data_tagid = '0; m_data_valid = 1'b0; m_data_last = 1'b0; m_resp_accept = 1'b0;
    dataByteen = 4'hF;
    for (int i = 0; i < 8; i++) memModel[i] = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                64'({s_cmd_accept, s_data_accept, s_resp, s_data, s_resp_last, s_tagid}), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset_release_accept", 64'(s_cmd_accept), 64'd1);

    wq.push_back(32'hDEADBEEF);
    applyStimulus(3'd1, 5'h04, 4'd1, 3'd0, 4'hF, 5'd1, -1, -1, 1);
    applyStimulus(3'd2, 5'h04, 4'd1, 3'd0, 4'hF, 5'd3, -1, -1, 1);

    for (int i = 1; i <= 4; i++) wq.push_back(32'(i));
    applyStimulus(3'd5, 5'h18, 4'd4, 3'd0, 4'hF, 5'd2, -1, -1, 1);
    applyStimulus(3'd2, 5'h18, 4'd4, 3'd0, 4'hF, 5'd4, -1, -1, 1);

    // Read burst with a two-cycle stall on its second beat.
    acceptMode = 1'b1;
    m_resp_accept = 1'b1;
    pc = popCount;
    applyStimulus(3'd2, 5'h18, 4'd3, 3'd0, 4'hF, 5'd9, -1, -1, 0);
    @(posedge clk); #1;
    m_resp_accept = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    m_resp_accept = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("stall_beats", 64'(popCount - pc), 64'd3);
    checkOutput("stall_idle", 64'({s_cmd_accept, s_resp}), 64'({1'b1, 2'd0}));
    acceptMode = 1'b0;

    wq.push_back(32'h11223344);
    applyStimulus(3'd1, 5'h08, 4'd1, 3'd0, 4'hF, 5'd5, -1, -1, 1);
    dataByteen = 4'b0101;
    wq.push_back(32'hAABBCCDD);
    applyStimulus(3'd1, 5'h08, 4'd1, 3'd0, 4'hF, 5'd5, -1, -1, 1);
    dataByteen = 4'hF;
    applyStimulus(3'd2, 5'h08, 4'd1, 3'd0, 4'hF, 5'd6, -1, -1, 1);

    applyStimulus(3'd3, 5'h00, 4'd2, 3'd0, 4'hF, 5'd7, -1, -1, 1);
    applyStimulus(3'd5, 5'h0C, 4'd2, 3'd1, 4'hF, 5'd8, -1, -1, 1);
    applyStimulus(3'd2, 5'h0C, 4'd2, 3'd0, 4'hF, 5'd8, -1, -1, 1);
    applyStimulus(3'd5, 5'h10, 4'd2, 3'd0, 4'hF, 5'd10, 1, -1, 1);
    applyStimulus(3'd2, 5'h10, 4'd0, 3'd0, 4'hF, 5'd11, -1, -1, 1);

    for (int n = 0; n < 40; n++) begin
      logic [2:0] c;
      c = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(1, 7))
                                      : ((n % 3 == 0) ? 3'd1 : ((n % 3 == 1) ? 3'd2 : 3'd5));
      dataByteen = 4'($urandom);
      applyStimulus(c, 5'($urandom), 4'($urandom_range(0, 5)),
                    ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                    4'($urandom), 5'($urandom),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1,
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1, 1);
    end
    dataByteen = 4'hF;

    // Reset while the second beat of a four-beat read is pending.
    acceptMode = 1'b1;
    m_resp_accept = 1'b1;
    applyStimulus(3'd2, 5'h00, 4'd4, 3'd0, 4'hF, 5'd12, -1, -1, 0);
    @(posedge clk); #1;
    m_resp_accept = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_midburst_outputs",
                64'({s_cmd_accept, s_data_accept, s_resp, s_data, s_resp_last, s_tagid}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    expQ.delete();
    for (int i = 0; i < 8; i++) memModel[i] = 32'd0;
    #1;
    checkOutput("post_rst_idle", 64'({s_cmd_accept, s_resp}), 64'({1'b1, 2'd0}));
    acceptMode = 1'b0;
    applyStimulus(3'd2, 5'h00, 4'd8, 3'd0, 4'hF, 5'd13, -1, -1, 1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
